// File: rtl/img_stream_source.sv
// img_stream_source: credit-paced AXI-stream pixel source reading a frame memory in raster order.
// Define IMG_STREAM_TLAST_EN to drive o_data_last on the final pixel of every line.
module img_stream_source #(
  parameter int IMG_WIDTH     = 512,
  parameter int IMG_HEIGHT    = 512,
  parameter int PRELOAD_LINES = 4,
  parameter int ADDR_W        = 18
) (
  input  logic              axi_clk,
  input  logic              axi_reset_n,
  input  logic              i_start,
  input  logic              i_intr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [7:0]        i_mem_data,
  output logic              o_data_valid,
  output logic [7:0]        o_data,
  output logic              o_data_last,
  input  logic              i_data_ready
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int LW = IMG_HEIGHT > 1 ? $clog2(IMG_HEIGHT) : 1;
  localparam int KW = $clog2(IMG_HEIGHT + 1);
`ifdef IMG_STREAM_TLAST_EN
  localparam int FW = 9;
`else
  localparam int FW = 8;
`endif
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_CREDIT, DRAIN, DONE} state_t;
  state_t                 state_q, state_d;
  logic [CW-1:0]          col_q, col_d;
  logic [LW-1:0]          line_q, line_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [KW-1:0]          credit_q, credit_d;
  logic                   infl_q;
  logic [1:0][FW-1:0]     fifo_q, fifo_d;
  logic                   wr_q, wr_d, rd_q, rd_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [2:0]             occ;
  logic                   pop, rd_en, line_end, last_line, consume, inc;
  logic [FW-1:0]          push_word;
  // Occupancy counts the entry leaving this cycle so a read can overlap a pop.
  assign pop       = cnt_q != 2'd0 && i_data_ready;
  assign occ       = {1'b0, cnt_q} + {2'b0, infl_q} - {2'b0, pop};
  assign rd_en     = state_q == LOAD && occ < 3'd2 && (col_q != '0 || credit_q != '0);
  assign line_end  = col_q == CW'(IMG_WIDTH - 1);
  assign last_line = line_q == LW'(IMG_HEIGHT - 1);
  assign consume   = rd_en && col_q == '0;
  assign inc       = i_intr && (state_q == LOAD || state_q == WAIT_CREDIT || state_q == DRAIN);
`ifdef IMG_STREAM_TLAST_EN
  logic last_q;
  always_ff @(posedge axi_clk or negedge axi_reset_n)
    if (!axi_reset_n) last_q <= 1'b0;
    else last_q <= rd_en && line_end;
  assign push_word   = {last_q, i_mem_data};
  assign o_data_last = fifo_q[rd_q][8];
`else
  assign push_word   = i_mem_data;
  assign o_data_last = 1'b0;
`endif
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    line_d   = line_q;
    addr_d   = addr_q;
    credit_d = inc && !consume ? credit_q + KW'(credit_q != KW'(IMG_HEIGHT))
                               : credit_q - KW'(consume && !inc);
    cnt_d    = cnt_q + {1'b0, infl_q} - {1'b0, pop};
    wr_d     = wr_q ^ infl_q;
    rd_d     = rd_q ^ pop;
    fifo_d   = fifo_q;
    if (infl_q) fifo_d[wr_q] = push_word;
    if (rd_en) begin
      col_d  = line_end ? '0 : col_q + CW'(1);
      line_d = line_q + LW'(line_end);
      addr_d = addr_q + ADDR_W'(1);
    end
    case (state_q)
      IDLE: begin
        col_d    = '0;
        line_d   = '0;
        addr_d   = '0;
        credit_d = KW'(PRELOAD_LINES);
        if (i_start) state_d = LOAD;
      end
      LOAD:
        if (rd_en && line_end) state_d = last_line ? DRAIN : credit_d == '0 ? WAIT_CREDIT : LOAD;
        else if (col_q == '0 && credit_q == '0) state_d = WAIT_CREDIT;
      WAIT_CREDIT: if (credit_q != '0) state_d = LOAD;
      DRAIN: if (cnt_d == 2'd0 && !infl_q) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge axi_clk or negedge axi_reset_n)
    if (!axi_reset_n) begin
      state_q  <= IDLE;
      col_q    <= '0;
      line_q   <= '0;
      addr_q   <= '0;
      credit_q <= '0;
      infl_q   <= 1'b0;
      fifo_q   <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      line_q   <= line_d;
      addr_q   <= addr_d;
      credit_q <= credit_d;
      infl_q   <= rd_en;
      fifo_q   <= fifo_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
    end
  assign o_busy       = state_q == LOAD || state_q == WAIT_CREDIT || state_q == DRAIN;
  assign o_done       = state_q == DONE;
  assign o_mem_rd_en  = rd_en;
  assign o_mem_addr   = addr_q;
  assign o_data_valid = cnt_q != 2'd0;
  assign o_data       = fifo_q[rd_q][7:0];
endmodule

// File: tb/tb_img_stream_source.sv
// tb_img_stream_source: directed bench for img_stream_source on an 8x6 frame with memory[a]=a.
module tb_img_stream_source;
  localparam int W = 8, H = 6, P = 4, AW = 6;
  logic clk = 0, rst_n = 0, start = 0, intr = 0, ready = 0;
  logic busy, done, rd_en, valid, last;
  logic [AW-1:0] addr;
  logic [7:0] mdata = 0, data;
  int errors = 0, checks = 0, cyc = 0, ndone = 0, dcyc = 0, nrd;
  logic dbusy = 0, pend = 0, plast = 0;
  logic [7:0] pdata = 0;
  int beats[$], bcyc[$];
  logic lasts[$];

  always #5 clk = ~clk;

  img_stream_source #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PRELOAD_LINES(P), .ADDR_W(AW)) dut (
    .axi_clk(clk), .axi_reset_n(rst_n), .i_start(start), .i_intr(intr),
    .o_busy(busy), .o_done(done), .o_mem_rd_en(rd_en), .o_mem_addr(addr),
    .i_mem_data(mdata), .o_data_valid(valid), .o_data(data), .o_data_last(last),
    .i_data_ready(ready)
  );

  always @(posedge clk) if (rd_en) mdata <= 8'(addr);

  // Beat capture plus hold check on every valid-without-ready cycle.
  always @(posedge clk) begin
    if (rst_n) begin
      if (pend) begin
        checks++;
        assert (valid === 1'b1 && data === pdata && last === plast) else begin
          errors++;
          $error("FAIL hold: got v=%0b d=%0d l=%0b expected v=1 d=%0d l=%0b", valid, data, last, pdata, plast);
        end
      end
      pend = valid && !ready;
      pdata = data;
      plast = last;
      if (valid && ready) begin
        beats.push_back(int'(data));
        lasts.push_back(last);
        bcyc.push_back(cyc);
      end
      if (done) begin
        ndone++;
        dcyc = cyc;
        dbusy = busy;
      end
    end else pend = 0;
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int beat(input int i);
    return i < beats.size() ? beats[i] : -1;
  endfunction

  function automatic logic exp_last(input int i);
`ifdef IMG_STREAM_TLAST_EN
    return i % W == W - 1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic clear();
    beats.delete();
    bcyc.delete();
    lasts.delete();
    ndone = 0;
  endtask

  task automatic wait_done(input int lim);
    for (int k = 0; k < lim && ndone == 0; k++) step();
    chk("done_seen", ndone != 0, 1);
  endtask

  task automatic zero_outs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd"}, rd_en, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_last"}, last, 0);
  endtask

  initial begin
    repeat (3) begin
      start = ~start;
      intr = ~intr;
      ready = ~ready;
      @(negedge clk);
    end
    zero_outs("rst");
    start = 0;
    intr = 0;
    ready = 1;
    @(negedge clk);
    rst_n = 1;
    nrd = 0;
    repeat (20) begin
      step();
      if (rd_en) nrd++;
    end
    chk("idle_no_read", nrd, 0);

    // Preload burst then credit-paced completion.
    clear();
    start = 1;
    step();
    start = 0;
    chk("start_busy", busy, 1);
    chk("start_rd", rd_en, 1);
    chk("start_addr", addr, 0);
    chk("valid_n1", valid, 0);
    step();
    chk("valid_n2", valid, 0);
    step();
    chk("valid_n3", valid, 1);
    chk("first_data", data, 0);
    repeat (60) step();
    chk("preload_beats", beats.size(), 32);
    for (int i = 0; i < 32; i++) chk("preload_data", beat(i), i);
    chk("preload_b2b", bcyc.size() == 32 ? bcyc[31] - bcyc[0] : -1, 31);
    chk("stall_busy", busy, 1);
    chk("stall_valid", valid, 0);
    chk("stall_rd", rd_en, 0);
    intr = 1;
    step();
    intr = 0;
    chk("credit_m", rd_en, 0);
    step();
    chk("credit_m1_rd", rd_en, 1);
    chk("credit_m1_addr", addr, 32);
    repeat (30) step();
    chk("line4_beats", beats.size(), 40);
    intr = 1;
    step();
    intr = 0;
    wait_done(100);
    chk("frame_beats", beats.size(), 48);
    for (int i = 32; i < 48; i++) chk("credit_data", beat(i), i);
    chk("done_timing", dcyc, bcyc.size() == 48 ? bcyc[47] + 1 : -1);
    chk("done_busy", dbusy, 0);
    chk("after_done_busy", busy, 0);
    repeat (3) step();
    chk("done_once", ndone, 1);

    // Random backpressure over a full frame.
    clear();
    start = 1;
    step();
    start = 0;
    for (int k = 0; k < 600 && ndone == 0; k++) begin
      ready = $urandom_range(0, 3) != 0;
      intr = k == 3 || k == 5;
      step();
    end
    ready = 1;
    intr = 0;
    chk("bp_done", ndone, 1);
    chk("bp_beats", beats.size(), 48);
    for (int i = 0; i < 48; i++) begin
      chk("bp_data", beat(i), i);
      chk("bp_last", i < lasts.size() ? lasts[i] : 1'bx, exp_last(i));
    end

    // Credit added in the same cycle one is consumed, then surplus credits.
    clear();
    start = 1;
    step();
    start = 0;
    intr = 1;
    chk("sim_rd", rd_en, 1);
    chk("sim_addr", addr, 0);
    step();
    intr = 0;
    repeat (70) step();
    chk("sim_beats", beats.size(), 40);
    chk("sim_busy", busy, 1);
    intr = 1;
    repeat (10) step();
    intr = 0;
    wait_done(100);
    nrd = 0;
    repeat (20) begin
      step();
      if (rd_en) nrd++;
    end
    chk("extra_no_read", nrd, 0);
    chk("extra_beats", beats.size(), 48);
    chk("extra_lastdata", beat(47), 47);
    chk("extra_done_once", ndone, 1);

    // Reset in the middle of line 2, then restart from pixel 0.
    clear();
    start = 1;
    step();
    start = 0;
    for (int k = 0; k < 100 && !(rd_en && addr == 19); k++) step();
    chk("reach_line2", addr, 19);
    #2 rst_n = 0;
    #1 zero_outs("midrst");
    step();
    step();
    rst_n = 1;
    clear();
    nrd = 0;
    repeat (5) begin
      step();
      if (rd_en) nrd++;
    end
    chk("postrst_no_read", nrd, 0);
    chk("postrst_busy", busy, 0);
    start = 1;
    step();
    start = 0;
    repeat (60) step();
    chk("restart_beats", beats.size(), 32);
    chk("restart_first", beat(0), 0);
    chk("restart_last", beat(31), 31);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
